// File: rtl/sdram_arbiter.sv
// Arbitrates single-word SDRAM commands between two requester ports and an
// auto-refresh scheduler. Refresh has strict priority. The two ports share the
// controller round-robin.
module sdram_arbiter #(
    parameter int ADDR_W           = 24,
    parameter int DATA_W           = 16,
    parameter int REFRESH_INTERVAL = 374,
    parameter int TIMEOUT          = 255
) (
    input  logic              CLK_48MHZ,
    input  logic              RESET,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              DONE0,
    output logic              DONE1,
    output logic              RVALID0,
    output logic              RVALID1,
    output logic [DATA_W-1:0] RDATA,
    output logic              CMD_VALID,
    input  logic              CMD_READY,
    output logic [1:0]        CMD_OP,
    output logic [ADDR_W-1:0] CMD_ADDR,
    output logic [DATA_W-1:0] CMD_WDATA,
    input  logic              CTRL_RVALID,
    input  logic [DATA_W-1:0] CTRL_RDATA,
    input  logic              CTRL_DONE,
    output logic              REFRESH_OVF,
    output logic              TIMEOUT_ERR
);

    localparam int RT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [RT_W-1:0] RT_LAST = RT_W'(REFRESH_INTERVAL - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_REFRESH = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t          state;
    logic            last_port;
    logic            owner;
    logic [RT_W-1:0] rt_cnt;
    logic [TO_W-1:0] wait_cnt;
    logic [2:0]      pending;

    logic tick;
    logic ref_done;
    logic pick1;
    logic is_refresh;

    // Backlog counter: saturates at 7; a tick and a completion on the same edge cancel.
    function automatic logic [2:0] pending_next(input logic [2:0] cnt,
                                                input logic       inc,
                                                input logic       dec);
        logic [2:0] nxt;
        nxt = cnt;
        case ({inc, dec})
            2'b10:   nxt = (cnt == 3'd7) ? cnt : cnt + 3'd1;
            2'b01:   nxt = (cnt == 3'd0) ? cnt : cnt - 3'd1;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

    assign tick       = (rt_cnt == RT_LAST);
    assign is_refresh = (CMD_OP == OP_REFRESH);
    assign ref_done   = (state == WAIT) && is_refresh && CTRL_DONE;
    // Port 1 wins when it is alone, or on a tie when port 0 was granted last.
    assign pick1      = REQ1 && (!REQ0 || !last_port);

    always_ff @(posedge CLK_48MHZ or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            last_port   <= 1'b1;
            owner       <= 1'b0;
            rt_cnt      <= '0;
            wait_cnt    <= '0;
            pending     <= '0;
            GNT0        <= 1'b0;
            GNT1        <= 1'b0;
            DONE0       <= 1'b0;
            DONE1       <= 1'b0;
            RVALID0     <= 1'b0;
            RVALID1     <= 1'b0;
            RDATA       <= '0;
            CMD_VALID   <= 1'b0;
            CMD_OP      <= OP_READ;
            CMD_ADDR    <= '0;
            CMD_WDATA   <= '0;
            REFRESH_OVF <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            GNT0    <= 1'b0;
            GNT1    <= 1'b0;
            DONE0   <= 1'b0;
            DONE1   <= 1'b0;
            RVALID0 <= 1'b0;
            RVALID1 <= 1'b0;

            rt_cnt  <= tick ? '0 : rt_cnt + RT_W'(1);
            pending <= pending_next(pending, tick, ref_done);
            if (tick && !ref_done && pending == 3'd7) begin
                REFRESH_OVF <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (pending != 3'd0) begin
                        CMD_OP    <= OP_REFRESH;
                        CMD_ADDR  <= '0;
                        CMD_WDATA <= '0;
                        CMD_VALID <= 1'b1;
                        state     <= ISSUE;
                    end else if (REQ0 || REQ1) begin
                        owner     <= pick1;
                        last_port <= pick1;
                        CMD_VALID <= 1'b1;
                        state     <= ISSUE;
                        if (pick1) begin
                            GNT1      <= 1'b1;
                            CMD_OP    <= WE1 ? OP_WRITE : OP_READ;
                            CMD_ADDR  <= ADDR1;
                            CMD_WDATA <= WE1 ? WDATA1 : '0;
                        end else begin
                            GNT0      <= 1'b1;
                            CMD_OP    <= WE0 ? OP_WRITE : OP_READ;
                            CMD_ADDR  <= ADDR0;
                            CMD_WDATA <= WE0 ? WDATA0 : '0;
                        end
                    end
                end

                ISSUE: begin
                    if (CMD_READY) begin
                        CMD_VALID <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= WAIT;
                    end
                end

                WAIT: begin
                    if (CTRL_RVALID && CMD_OP == OP_READ) begin
                        RDATA   <= CTRL_RDATA;
                        RVALID0 <= !owner;
                        RVALID1 <= owner;
                    end
                    // Completion wins over a timeout landing on the same edge.
                    if (CTRL_DONE) begin
                        if (!is_refresh) begin
                            DONE0 <= !owner;
                            DONE1 <= owner;
                        end
                        state <= IDLE;
                    end else if (wait_cnt == TO_LAST) begin
                        TIMEOUT_ERR <= 1'b1;
                        if (!is_refresh) begin
                            DONE0 <= !owner;
                            DONE1 <= owner;
                        end
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: vector table for single transactions,
// hand sequences for round-robin, timeout, reset abort and refresh backlog.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [23:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        cmd_ready, ctrl_rvalid, ctrl_done;
    logic [15:0] ctrl_rdata;

    logic        gnt0, gnt1, done0, done1, rvalid0, rvalid1;
    logic [15:0] rdata;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        refresh_ovf, timeout_err;

    logic        r_gnt0, r_gnt1, r_done0, r_done1, r_rvalid0, r_rvalid1;
    logic [15:0] r_rdata;
    logic        r_cmd_valid;
    logic [1:0]  r_cmd_op;
    logic [23:0] r_cmd_addr;
    logic [15:0] r_cmd_wdata;
    logic        r_refresh_ovf, r_timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_W(24), .DATA_W(16), .REFRESH_INTERVAL(374), .TIMEOUT(255)) dut (
        .CLK_48MHZ(clk), .RESET(rst),
        .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
        .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wdata0), .WDATA1(wdata1),
        .GNT0(gnt0), .GNT1(gnt1), .DONE0(done0), .DONE1(done1),
        .RVALID0(rvalid0), .RVALID1(rvalid1), .RDATA(rdata),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op),
        .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
        .CTRL_RVALID(ctrl_rvalid), .CTRL_RDATA(ctrl_rdata), .CTRL_DONE(ctrl_done),
        .REFRESH_OVF(refresh_ovf), .TIMEOUT_ERR(timeout_err)
    );

    sdram_arbiter #(.ADDR_W(24), .DATA_W(16), .REFRESH_INTERVAL(16), .TIMEOUT(255)) dut_r (
        .CLK_48MHZ(clk), .RESET(rst),
        .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
        .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wdata0), .WDATA1(wdata1),
        .GNT0(r_gnt0), .GNT1(r_gnt1), .DONE0(r_done0), .DONE1(r_done1),
        .RVALID0(r_rvalid0), .RVALID1(r_rvalid1), .RDATA(r_rdata),
        .CMD_VALID(r_cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(r_cmd_op),
        .CMD_ADDR(r_cmd_addr), .CMD_WDATA(r_cmd_wdata),
        .CTRL_RVALID(ctrl_rvalid), .CTRL_RDATA(ctrl_rdata), .CTRL_DONE(ctrl_done),
        .REFRESH_OVF(r_refresh_ovf), .TIMEOUT_ERR(r_timeout_err)
    );

    typedef struct packed {
        logic        req0, req1, we0, we1;
        logic [23:0] addr0, addr1;
        logic [15:0] wdata0, wdata1;
        logic        ready, crv, cdone;
        logic [15:0] crdata;
        logic [5:0]  pulses;   // {gnt0, gnt1, done0, done1, rvalid0, rvalid1}
        logic        valid;
        logic [1:0]  op;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;

    localparam int NVEC = 21;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        cmd_ready = 0; ctrl_rvalid = 0; ctrl_done = 0; ctrl_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        logic [5:0] act_p;
        logic nexp;
        int ngrant, first_ref, n_ref, gnt_e;
        logic rv_seen;

        //   req0 req1 we0  we1  addr0         addr1         wdata0    wdata1    rdy  crv  cdone crdata  | pulses     vld  op     addr          wdata     rdata
        tbl[0]  = '{1'b1,1'b0,1'b1,1'b0,24'h012345,24'h000000,16'hBEEF,16'h0000,1'b0,1'b0,1'b0,16'h0000, 6'b100000,1'b1,2'b01,24'h012345,16'hBEEF,16'h0000};
        tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,24'h012345,24'h000000,16'hBEEF,16'h0000,1'b0,1'b0,1'b0,16'h0000, 6'b000000,1'b1,2'b01,24'h012345,16'hBEEF,16'h0000};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,24'hFFFFFF,24'h000000,16'h0000,16'h0000,1'b0,1'b0,1'b0,16'h0000, 6'b000000,1'b1,2'b01,24'h012345,16'hBEEF,16'h0000};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,24'h000000,24'h000000,16'h0000,16'h0000,1'b1,1'b0,1'b0,16'h0000, 6'b000000,1'b0,2'b00,24'h000000,16'h0000,16'h0000};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,24'h000000,24'h000000,16'h0000,16'h0000,1'b0,1'b0,1'b0,16'h0000, 6'b000000,1'b0,2'b00,24'h000000,16'h0000,16'h0000};
        tbl[5]  = tbl[4];
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,24'h000000,24'h000000,16'h0000,16'h0000,1'b0,1'b0,1'b1,16'h0000, 6'b001000,1'b0,2'b00,24'h000000,16'h0000,16'h0000};
        tbl[7]  = tbl[4];
        tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,24'h000000,24'h00ABCD,16'h0000,16'h7777,1'b0,1'b0,1'b0,16'h0000, 6'b010000,1'b1,2'b00,24'h00ABCD,16'h0000,16'h0000};
        tbl[9]  = tbl[3];
        tbl[10] = '{1'b0,1'b0,1'b0,1'b0,24'h000000,24'h000000,16'h0000,16'h0000,1'b0,1'b1,1'b0,16'h5A5A, 6'b000001,1'b0,2'b00,24'h000000,16'h0000,16'h5A5A};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0,24'h000000,24'h000000,16'h0000,16'h0000,1'b0,1'b0,1'b1,16'h0000, 6'b000100,1'b0,2'b00,24'h000000,16'h0000,16'h0000};
        tbl[12] = tbl[4];
        tbl[13] = '{1'b1,1'b0,1'b0,1'b0,24'hFFFFFF,24'h000000,16'h0000,16'h0000,1'b0,1'b0,1'b0,16'h0000, 6'b100000,1'b1,2'b00,24'hFFFFFF,16'h0000,16'h0000};
        tbl[14] = tbl[3];
        tbl[15] = '{1'b0,1'b0,1'b0,1'b0,24'h000000,24'h000000,16'h0000,16'h0000,1'b0,1'b1,1'b1,16'h1234, 6'b001010,1'b0,2'b00,24'h000000,16'h0000,16'h1234};
        tbl[16] = tbl[4];
        tbl[17] = '{1'b0,1'b1,1'b0,1'b1,24'h000000,24'h000001,16'h0000,16'hFFFF,1'b1,1'b0,1'b0,16'h0000, 6'b010000,1'b1,2'b01,24'h000001,16'hFFFF,16'h0000};
        tbl[18] = tbl[3];
        tbl[19] = '{1'b0,1'b0,1'b0,1'b0,24'h000000,24'h000000,16'h0000,16'h0000,1'b0,1'b1,1'b1,16'hAAAA, 6'b000100,1'b0,2'b00,24'h000000,16'h0000,16'h0000};
        tbl[20] = tbl[4];

        // Reset state
        rst = 1'b0;
        clear_inputs();
        #2 rst = 1'b1;
        #1;
        check("reset_pulses", {gnt0, gnt1, done0, done1, rvalid0, rvalid1}, 64'h0);
        check("reset_cmd", {cmd_valid, cmd_op, cmd_addr, cmd_wdata}, 64'h0);
        check("reset_rdata_flags", {rdata, refresh_ovf, timeout_err}, 64'h0);
        check("reset_r_outputs", {r_gnt0, r_gnt1, r_cmd_valid, r_cmd_op, r_refresh_ovf, r_timeout_err}, 64'h0);
        tick();
        rst = 1'b0;

        // Single transactions from the vector table
        for (int i = 0; i < NVEC; i++) begin
            req0 = tbl[i].req0; req1 = tbl[i].req1; we0 = tbl[i].we0; we1 = tbl[i].we1;
            addr0 = tbl[i].addr0; addr1 = tbl[i].addr1;
            wdata0 = tbl[i].wdata0; wdata1 = tbl[i].wdata1;
            cmd_ready = tbl[i].ready; ctrl_rvalid = tbl[i].crv;
            ctrl_done = tbl[i].cdone; ctrl_rdata = tbl[i].crdata;
            tick();
            act_p = {gnt0, gnt1, done0, done1, rvalid0, rvalid1};
            ok = (act_p == tbl[i].pulses) && (cmd_valid == tbl[i].valid) &&
                 !refresh_ovf && !timeout_err;
            if (tbl[i].valid)
                ok = ok && (cmd_op == tbl[i].op) && (cmd_addr == tbl[i].addr) &&
                     (cmd_wdata == tbl[i].wdata);
            if (tbl[i].pulses[1] || tbl[i].pulses[0])
                ok = ok && (rdata == tbl[i].rdata);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL vec%0d: got p=%b v=%b op=%b a=%h wd=%h rd=%h, expected p=%b v=%b op=%b a=%h wd=%h rd=%h",
                         i, act_p, cmd_valid, cmd_op, cmd_addr, cmd_wdata, rdata,
                         tbl[i].pulses, tbl[i].valid, tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].rdata);
            end
        end

        // Round-robin with both ports requesting continuously
        do_reset();
        req0 = 1; req1 = 1; we0 = 1; wdata0 = 16'h1111; wdata1 = 16'h2222;
        cmd_ready = 1; ctrl_done = 1;
        nexp = 1'b0;
        ngrant = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            check("rr_exclusive", {63'h0, gnt0 & gnt1}, 64'h0);
            if (gnt0 || gnt1) begin
                check("rr_order", {63'h0, gnt1}, {63'h0, nexp});
                nexp = ~nexp;
                ngrant++;
            end
        end
        check("rr_grant_count", 64'(ngrant), 64'd8);

        // Timeout on a port 1 read
        do_reset();
        req1 = 1; addr1 = 24'h000042;
        tick();
        check("to_gnt1", {63'h0, gnt1}, 64'h1);
        req1 = 0; cmd_ready = 1;
        tick();
        cmd_ready = 0;
        rv_seen = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (rvalid1) rv_seen = 1'b1;
            if (i == 254) check("to_before", {62'h0, timeout_err, done1}, 64'h0);
            if (i == 255) check("to_at", {62'h0, timeout_err, done1}, 64'h3);
        end
        check("to_no_rvalid1", {63'h0, rv_seen}, 64'h0);
        req0 = 1;
        tick();
        check("to_idle_regrant", {61'h0, timeout_err, done1, gnt0}, 64'h5);

        // Reset in the middle of a read in WAIT
        req0 = 0; cmd_ready = 1;
        tick();
        cmd_ready = 0;
        check("rst_pre", {62'h0, cmd_valid, timeout_err}, 64'h1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_pulses", {gnt0, gnt1, done0, done1, rvalid0, rvalid1}, 64'h0);
        check("rst_async_cmd", {cmd_valid, cmd_op, cmd_addr, cmd_wdata}, 64'h0);
        check("rst_async_flags", {rdata, refresh_ovf, timeout_err}, 64'h0);
        ctrl_rvalid = 1; ctrl_done = 1; ctrl_rdata = 16'hDEAD;
        tick();
        check("rst_hold_no_done", {done0, done1, rvalid0, rvalid1}, 64'h0);
        rst = 1'b0;
        tick();
        check("rst_after_no_done", {cmd_valid, done0, done1, rvalid0, rvalid1, timeout_err}, 64'h0);

        // Refresh priority and backlog (REFRESH_INTERVAL = 16 instance)
        do_reset();
        req0 = 1; addr0 = 24'h0000AA; cmd_ready = 1; ctrl_done = 1;
        first_ref = 0;
        for (int e = 1; e <= 22; e++) begin
            tick();
            if (r_cmd_valid && r_cmd_op == 2'b10 && first_ref == 0) begin
                first_ref = e;
                check("ref_no_gnt0", {63'h0, r_gnt0}, 64'h0);
            end
            if (e == 22) check("ref_port_resumes", {61'h0, r_gnt0, r_cmd_op}, 64'h4);
        end
        check("ref_first_edge", 64'(first_ref), 64'd19);
        cmd_ready = 0;
        for (int e = 23; e <= 150; e++) begin
            tick();
            if (e == 143) check("ovf_before", {63'h0, r_refresh_ovf}, 64'h0);
            if (e == 144) check("ovf_set", {63'h0, r_refresh_ovf}, 64'h1);
        end
        // Backlog of 7 drains; two more ticks arrive while draining (one cancels a completion)
        cmd_ready = 1;
        n_ref = 0;
        gnt_e = 0;
        for (int e = 151; e <= 220; e++) begin
            tick();
            if (r_cmd_valid && r_cmd_op == 2'b10) n_ref++;
            if (r_gnt0) begin
                gnt_e = e;
                break;
            end
        end
        check("ref_drain_count", 64'(n_ref), 64'd9);
        check("ref_drain_regrant_edge", 64'(gnt_e), 64'd180);
        check("ovf_sticky", {63'h0, r_refresh_ovf}, 64'h1);

        clear_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
